// File: rtl/spi_flash_responder_if.sv
// Wishbone classic bus bundle for the SPI flash responder.
// The shared read-data bus stays a plain tri-state port on the responder.
interface spi_flash_responder_if;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport master (
        output cyc_i, stb_i, adr_i, sel_i, we_i, dat_i,
        input  ack_o, err_o, rty_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, sel_i, we_i, dat_i,
        output ack_o, err_o, rty_o
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Read-only Wishbone responder: each word read becomes one SPI READ (0x03) frame.
// state  | meaning
// IDLE   | waiting for an in-window strobe
// CMD    | shifting command byte 0x03
// ADDR   | shifting 24-bit word-aligned flash offset
// DATA   | shifting in 32 data bits (dummy zeros out)
// DONE   | one-cycle ack with assembled word on dat_o
// ERR    | one-cycle err for an in-window write
module spi_flash_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter logic [31:0] SIZE         = 32'h0100_0000,
    parameter int unsigned CLK_DIV      = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    spi_flash_responder_if.slave        bus,
    output wire [31:0]                  dat_o,
    output logic                        spi_cs_no,
    output logic                        spi_sck_o,
    output logic                        spi_mosi_o,
    input  logic                        spi_miso_i
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDRESS} + {1'b0, SIZE};
    localparam logic [7:0] READ_CMD = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_ERR
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [63:0]      shreg;
    logic [31:0]      offset_full;
    logic             hit;
    logic             req;
    logic             shifting;
    logic             phase_end;
    logic             bit_end;
    logic             start;
    logic             unused_bits;

    assign offset_full = bus.adr_i - BASE_ADDRESS;
    assign hit         = (bus.adr_i >= BASE_ADDRESS) && ({1'b0, bus.adr_i} < WIN_END);
    assign req         = bus.cyc_i && bus.stb_i && hit;
    assign shifting    = state inside {S_CMD, S_ADDR, S_DATA};
    assign phase_end   = (div_cnt == DIV_LAST);
    assign bit_end     = phase_end && spi_sck_o;
    assign start       = (state == S_IDLE) && req && !bus.we_i;
    assign unused_bits = ^{bus.sel_i, bus.dat_i, offset_full[31:24], offset_full[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = bus.we_i ? S_ERR : S_CMD;
            end
            S_CMD: begin
                if (!bus.cyc_i)                       state_nxt = S_IDLE;
                else if (bit_end && bit_cnt == 6'd7)  state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (!bus.cyc_i)                       state_nxt = S_IDLE;
                else if (bit_end && bit_cnt == 6'd31) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!bus.cyc_i)                       state_nxt = S_IDLE;
                else if (bit_end && bit_cnt == 6'd63) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // SCK toggles every CLK_DIV cycles; MISO is captured on the rising toggle,
    // MOSI advances on the falling toggle so it only moves while SCK is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= '0;
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
        end else if (start) begin
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= {READ_CMD, offset_full[23:2], 2'b00, 32'h0};
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= READ_CMD[7];
        end else if (!shifting || !bus.cyc_i) begin
            bit_cnt    <= '0;
            div_cnt    <= '0;
            spi_sck_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
        end else if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt   <= '0;
            spi_sck_o <= !spi_sck_o;
            if (!spi_sck_o) begin
                shreg <= {shreg[62:0], spi_miso_i};
            end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                spi_mosi_o <= (bit_cnt == 6'd63) ? 1'b0 : shreg[63];
            end
        end
    end

    assign spi_cs_no = !shifting;
    assign bus.ack_o = (state == S_DONE);
    assign bus.err_o = (state == S_ERR);
    assign bus.rty_o = 1'b0;
    assign dat_o     = (state == S_DONE) ?
                       {shreg[7:0], shreg[15:8], shreg[23:16], shreg[31:24]} : 32'hzzzz_zzzz;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: two responders (CLK_DIV=1 and 2) each talking to a behavioural SPI NOR model.
`timescale 1ns/1ps
module tb_spi_flash_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int compared = 0;
    int mismatched = 0;

    spi_flash_responder_if bus_a ();
    spi_flash_responder_if bus_b ();
    wire [31:0] dat_a, dat_b;
    logic cs_a, sck_a, mosi_a;
    logic cs_b, sck_b, mosi_b;
    logic miso_a = 1'b0;
    logic miso_b = 1'b0;

    spi_flash_responder #(.CLK_DIV(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_a), .bus(bus_a), .dat_o(dat_a),
        .spi_cs_no(cs_a), .spi_sck_o(sck_a), .spi_mosi_o(mosi_a), .spi_miso_i(miso_a)
    );

    spi_flash_responder #(.CLK_DIV(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_b), .bus(bus_b), .dat_o(dat_b),
        .spi_cs_no(cs_b), .spi_sck_o(sck_b), .spi_mosi_o(mosi_b), .spi_miso_i(miso_b)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [31:0] hdr;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash contents: byte at a = (a[7:0] + 0x80) ^ {a[11:8], 4'h0}
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [7:0] b;
        b = a[7:0] + 8'h80;
        return b ^ {a[11:8], 4'h0};
    endfunction

    function automatic logic flash_bit(input logic [23:0] a, input int idx);
        logic [7:0] b;
        b = flash_byte(a + 24'(idx / 8));
        return b[7 - (idx % 8)];
    endfunction

    int cnt_a = 0, cnt_b = 0;
    logic [31:0] hdr_a = '0, hdr_b = '0;

    always @(posedge sck_a or posedge cs_a) begin
        if (cs_a) cnt_a = 0;
        else begin
            if (cnt_a < 32) hdr_a = {hdr_a[30:0], mosi_a};
            cnt_a = cnt_a + 1;
        end
    end
    always @(negedge sck_a)
        if (!cs_a && cnt_a >= 32 && cnt_a < 64) miso_a = flash_bit(hdr_a[23:0], cnt_a - 32);

    always @(posedge sck_b or posedge cs_b) begin
        if (cs_b) cnt_b = 0;
        else begin
            if (cnt_b < 32) hdr_b = {hdr_b[30:0], mosi_b};
            cnt_b = cnt_b + 1;
        end
    end
    always @(negedge sck_b)
        if (!cs_b && cnt_b >= 32 && cnt_b < 64) miso_b = flash_bit(hdr_b[23:0], cnt_b - 32);

    always @(negedge clk) begin
        if (bus_a.ack_o === 1'b1 || bus_a.err_o === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_resp", {bus_a.ack_o, bus_a.err_o}, 2'b00);
            end else begin
                ea = q_a.pop_front();
                check("a_kind_err", bus_a.err_o, ea.is_err);
                check("a_resp_cycle", cycle, ea.due);
                check("a_cs_in_resp", cs_a, 1'b1);
                if (!ea.is_err) begin
                    check("a_data", dat_a, ea.data);
                    check("a_mosi_hdr", hdr_a, ea.hdr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.ack_o === 1'b1 || bus_b.err_o === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_resp", {bus_b.ack_o, bus_b.err_o}, 2'b00);
            end else begin
                eb = q_b.pop_front();
                check("b_kind_err", bus_b.err_o, eb.is_err);
                check("b_resp_cycle", cycle, eb.due);
                check("b_cs_in_resp", cs_b, 1'b1);
                if (!eb.is_err) begin
                    check("b_data", dat_b, eb.data);
                    check("b_mosi_hdr", hdr_b, eb.hdr);
                end
            end
        end
    end

    task automatic drive(input bit on_b, input bit act, input bit we, input logic [31:0] adr);
        if (on_b) begin
            bus_b.cyc_i = act; bus_b.stb_i = act; bus_b.we_i = we; bus_b.adr_i = adr;
            bus_b.sel_i = 4'hF; bus_b.dat_i = 32'hDEAD_BEEF;
        end else begin
            bus_a.cyc_i = act; bus_a.stb_i = act; bus_a.we_i = we; bus_a.adr_i = adr;
            bus_a.sel_i = 4'h5; bus_a.dat_i = 32'h1234_5678;
        end
    endtask

    task automatic access(input bit on_b, input logic [31:0] adr, input bit we, input bit respond,
                          input logic [31:0] exp_data, input logic [31:0] exp_hdr, input int budget);
        exp_t e;
        int e0;
        bit seen;
        int cs_low;
        logic [7:0] pat;
        logic ack, err, cs;
        seen = 1'b0;
        cs_low = 0;
        pat = '0;
        @(negedge clk);
        e0 = cycle + 1;
        e.is_err = we;
        e.data = exp_data;
        e.hdr = exp_hdr;
        e.due = we ? e0 : e0 + 128 * (on_b ? 2 : 1);
        if (respond) begin
            if (on_b) q_b.push_back(e);
            else q_a.push_back(e);
        end
        drive(on_b, 1'b1, we, adr);
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            ack = on_b ? bus_b.ack_o : bus_a.ack_o;
            err = on_b ? bus_b.err_o : bus_a.err_o;
            cs  = on_b ? cs_b : cs_a;
            if (i < 8) pat[i] = on_b ? sck_b : sck_a;
            if (!cs) cs_low++;
            if (ack || err) seen = 1'b1;
        end
        drive(on_b, 1'b0, 1'b0, 32'h0);
        check(respond ? "response_seen" : "miss_silent", seen, respond);
        if (we || !respond) check("cs_stayed_high", cs_low, 0);
        if (respond && !we) begin
            if (on_b) check("sck_period_div2", pat, 8'hCC);
            @(negedge clk);
            ack = on_b ? bus_b.ack_o : bus_a.ack_o;
            check("ack_one_cycle", ack, 1'b0);
            check("dat_released", on_b ? (dat_b === 32'hzzzz_zzzz || dat_b === 32'h0)
                                       : (dat_a === 32'hzzzz_zzzz || dat_a === 32'h0), 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_cs", cs_a, 1'b1);
        check("rst_sck", sck_a, 1'b0);
        check("rst_mosi", mosi_a, 1'b0);
        check("rst_ack_err_rty", {bus_a.ack_o, bus_a.err_o, bus_a.rty_o}, 3'b000);
        check("rst_dat_released", (dat_a === 32'hzzzz_zzzz || dat_a === 32'h0), 1'b1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        access(1'b0, 32'h1000_0000, 1'b0, 1'b1, 32'h8382_8180, 32'h0300_0000, 300);
        access(1'b0, 32'h1000_0106, 1'b0, 1'b1, 32'h9796_9594, 32'h0300_0104, 300);
        access(1'b0, 32'h1000_0000, 1'b1, 1'b1, 32'h0, 32'h0, 20);
        access(1'b0, 32'h2000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 200);
        access(1'b0, 32'h0FFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 20);
        access(1'b0, 32'h1100_0000, 1'b0, 1'b0, 32'h0, 32'h0, 20);
        access(1'b0, 32'h10FF_FFFC, 1'b0, 1'b1, 32'h8F8E_8D8C, 32'h03FF_FFFC, 300);

        // Abort while the address is being shifted out.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h1000_0000);
        repeat (20) @(negedge clk);
        check("abort_cs_active_before", cs_a, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("abort_cs", cs_a, 1'b1);
        check("abort_sck", sck_a, 1'b0);
        repeat (150) @(negedge clk);
        access(1'b0, 32'h1000_0004, 1'b0, 1'b1, 32'h8786_8584, 32'h0300_0004, 300);

        access(1'b1, 32'h1000_0208, 1'b0, 1'b1, 32'hABAA_A9A8, 32'h0300_0208, 600);

        // Asynchronous reset in the middle of the data phase.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0000);
        repeat (150) @(negedge clk);
        check("b_cs_active_mid_data", cs_b, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        check("b_async_rst_cs", cs_b, 1'b1);
        check("b_async_rst_sck", sck_b, 1'b0);
        check("b_async_rst_ack", bus_b.ack_o, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        rst_b = 1'b1;
        repeat (300) @(negedge clk);
        access(1'b1, 32'h1000_0000, 1'b0, 1'b1, 32'h8382_8180, 32'h0300_0000, 600);

        repeat (5) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
